proc_mem_responder: RTL and testbench

Memory-side responder for the 16-bit multi-cycle processor's bus. It owns a single-clock word RAM and serves two kinds of access. Instruction fetches are addressed by the processor's PC (R7). Data accesses use Daddress/q/w/memControl. It returns read data on DIN. A streaming program loader with a valid/ready handshake fills the RAM before the block raises Run to release the processor.

---
 rtl/proc_mem_responder_if.sv | 40 ++++
 rtl/proc_mem_responder.sv | 130 +++++++++++++
 tb/tb_proc_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_mem_responder_if.sv
// Bus bundle between the processor/loader side and the memory responder.
// master: processor + program loader (drive addresses, data, strobes, loader stream)
// slave : proc_mem_responder (returns DIN, handshake ready and status)
interface proc_mem_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    // Program loader stream
    logic              start_load;
    logic [ADDR_W:0]   load_len;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;

    // Processor memory port
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] Daddress;
    logic [DATA_W-1:0] q;
    logic              w;
    logic              memControl;
    logic [DATA_W-1:0] DIN;

    // Status
    logic              Run;
    logic [1:0]        state_o;
    logic [ADDR_W:0]   load_count;
    logic              oob_err;

    modport master (
        output start_load, load_len, load_data, load_valid,
        output pc, Daddress, q, w, memControl,
        input  load_ready, DIN, Run, state_o, load_count, oob_err
    );

    modport slave (
        input  start_load, load_len, load_data, load_valid,
        input  pc, Daddress, q, w, memControl,
        output load_ready, DIN, Run, state_o, load_count, oob_err
    );
endinterface

// File: rtl/proc_mem_responder.sv
// Memory-side responder for the 16-bit multi-cycle processor.
// Owns a 2^ADDR_W-word RAM, fills it from a valid/ready loader stream, then
// releases the processor (Run) and serves fetches (pc) and data accesses
// (Daddress/q/w/memControl) with one-cycle read latency on DIN.
// Ports:
//   Clock  - system clock, rising edge
//   Resetn - asynchronous active-low reset
//   bus    - proc_mem_responder_if.slave: loader stream, processor port, status
module proc_mem_responder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    proc_mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               run_q, run_d;
    logic               oob_q, oob_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [CNT_W-1:0]   len_clamped_c;
    logic               load_ready_c;
    logic               xfer_c;
    logic               run_active_c;
    logic [DATA_W-1:0]  used_addr_c;
    logic               addr_oob_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [DATA_W-1:0]  rd_word_c;

    // Loader and access decode
    always_comb begin
        len_clamped_c = (bus.load_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.load_len;
        load_ready_c  = (state_q == S_LOAD) && (count_q < len_q);
        xfer_c        = load_ready_c && bus.load_valid;
        run_active_c  = (state_q == S_RUN);
        // Data address governs range checking whenever a data access is requested.
        used_addr_c   = (bus.w || bus.memControl) ? bus.Daddress : bus.pc;
        addr_oob_c    = (used_addr_c >> ADDR_W) != '0;
        rd_addr_c     = bus.memControl ? bus.Daddress[ADDR_W-1:0] : bus.pc[ADDR_W-1:0];
        rd_word_c     = mem[rd_addr_c];
    end

    // RAM write port: loader while loading, processor stores while running
    always_ff @(posedge Clock) begin
        if (xfer_c) begin
            mem[count_q[ADDR_W-1:0]] <= bus.load_data;
        end else if (run_active_c && bus.w && !addr_oob_c) begin
            mem[bus.Daddress[ADDR_W-1:0]] <= bus.q;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        din_d   = din_q;
        oob_d   = oob_q;

        // Read-first: rd_word_c is the pre-write RAM content.
        if (run_active_c) begin
            din_d = addr_oob_c ? '0 : rd_word_c;
            oob_d = oob_q | addr_oob_c;
        end

        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                if (xfer_c) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_d == len_q) state_d = S_RUN;
                end else if (count_q == len_q) begin
                    // Zero-length load falls straight through to RUN.
                    state_d = S_RUN;
                end
            end
            S_RUN: ;
            default: state_d = S_IDLE;
        endcase

        // start_load aborts anything in progress and restarts the load.
        if (bus.start_load) begin
            state_d = S_LOAD;
            len_d   = len_clamped_c;
            count_d = '0;
        end

        run_d = (state_d == S_RUN);
    end

    // State registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            din_q   <= '0;
            run_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            din_q   <= din_d;
            run_q   <= run_d;
            oob_q   <= oob_d;
        end
    end

    assign bus.load_ready = load_ready_c;
    assign bus.DIN        = din_q;
    assign bus.Run        = run_q;
    assign bus.state_o    = state_q;
    assign bus.load_count = count_q;
    assign bus.oob_err    = oob_q;
endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: the driver advances a behavioural
// model each cycle and queues the expected outputs; a negedge monitor pops and
// compares them against the DUT.
module tb_proc_mem_responder;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;

    localparam int ST_IDLE = 0;
    localparam int ST_LOAD = 1;
    localparam int ST_RUN  = 2;

    typedef enum int {K_DIN, K_RUN, K_STATE, K_COUNT, K_OOB, K_READY} kind_t;
    typedef struct {
        int    cyc;
        kind_t kind;
        int    val;
    } exp_t;

    exp_t sb[$];

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model
    logic [15:0] ref_mem [DEPTH];
    bit          ref_oob;
    int          m_din;
    int          m_state;
    int          m_count;
    int          m_len;
    logic [15:0] prog[$];

    proc_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    proc_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int actual(kind_t k);
        case (k)
            K_DIN:   return int'(bus.DIN);
            K_RUN:   return int'(bus.Run);
            K_STATE: return int'(bus.state_o);
            K_COUNT: return int'(bus.load_count);
            K_OOB:   return int'(bus.oob_err);
            default: return int'(bus.load_ready);
        endcase
    endfunction

    // Monitor: compare every queued expectation due in this cycle
    always @(negedge Clock) begin
        exp_t e;
        int   act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s stale entry: due cycle %0d, now cycle %0d", e.kind.name(), e.cyc, cyc);
            end else begin
                act = actual(e.kind);
                if (act != e.val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: actual 0x%0h required 0x%0h", e.kind.name(), cyc, act, e.val);
                end
            end
        end
    end

    function automatic void sb_push(int c, kind_t k, int v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    function automatic void push_status(int c);
        sb_push(c, K_STATE, m_state);
        sb_push(c, K_RUN,   (m_state == ST_RUN) ? 1 : 0);
        sb_push(c, K_COUNT, m_count);
        sb_push(c, K_READY, (m_state == ST_LOAD && m_count < m_len) ? 1 : 0);
        sb_push(c, K_OOB,   ref_oob ? 1 : 0);
        sb_push(c, K_DIN,   m_din);
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_load = 1'b0;
        bus.load_len   = '0;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        bus.pc         = '0;
        bus.Daddress   = '0;
        bus.q          = '0;
        bus.w          = 1'b0;
        bus.memControl = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently on the bus.
    task automatic cycle();
        int used;
        bit oob;
        if (m_state == ST_RUN) begin
            used = (bus.w || bus.memControl) ? int'(bus.Daddress) : int'(bus.pc);
            oob  = used >= DEPTH;
            if (oob)                 m_din = 0;
            else if (bus.memControl) m_din = int'(ref_mem[int'(bus.Daddress) % DEPTH]);
            else                     m_din = int'(ref_mem[int'(bus.pc) % DEPTH]);
            if (bus.w && !oob) ref_mem[int'(bus.Daddress) % DEPTH] = bus.q;
            if (oob) ref_oob = 1'b1;
        end
        if (m_state == ST_LOAD) begin
            if (m_count < m_len) begin
                if (bus.load_valid) begin
                    ref_mem[m_count] = bus.load_data;
                    m_count++;
                    if (m_count == m_len) m_state = ST_RUN;
                end
            end else begin
                m_state = ST_RUN;
            end
        end
        if (bus.start_load) begin
            m_state = ST_LOAD;
            m_count = 0;
            m_len   = (int'(bus.load_len) > DEPTH) ? DEPTH : int'(bus.load_len);
        end
        push_status(cyc + 1);
        step();
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #1;
        Resetn = 1'b0;
        idle_inputs();
        m_state = ST_IDLE;
        m_count = 0;
        m_len   = 0;
        m_din   = 0;
        ref_oob = 1'b0;
        step();
        step();
        Resetn = 1'b1;
    endtask

    // mode 0: load_valid toggles 1/0; mode 1: random valid. stop_after<0 runs to completion.
    task automatic load_prog(int len, int mode, int stop_after);
        int i = 0;
        idle_inputs();
        bus.start_load = 1'b1;
        bus.load_len   = CNT_W'(len);
        cycle();
        bus.start_load = 1'b0;
        bus.load_len   = '0;
        while (m_state == ST_LOAD && m_count != stop_after) begin
            bus.load_valid = (mode == 0) ? (i % 2 == 0) : ($urandom_range(0, 2) != 0);
            bus.load_data  = (m_count < prog.size()) ? prog[m_count] : 16'($urandom);
            // Processor port noise must be ignored outside RUN.
            bus.w          = 1'($urandom);
            bus.memControl = 1'($urandom);
            bus.pc         = 16'($urandom);
            bus.Daddress   = 16'($urandom);
            bus.q          = 16'($urandom);
            cycle();
            i++;
        end
        idle_inputs();
    endtask

    task automatic access(int pc_v, int da, int qv, bit wv, bit mc);
        bus.pc         = 16'(pc_v);
        bus.Daddress   = 16'(da);
        bus.q          = 16'(qv);
        bus.w          = wv;
        bus.memControl = mc;
        cycle();
        idle_inputs();
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 65535));
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        m_state = ST_IDLE;
        m_count = 0;
        m_len   = 0;
        m_din   = 0;
        ref_oob = 1'b0;

        // Reset, then idle
        do_reset();
        repeat (3) cycle();

        // Four-word load with 1/0 valid backpressure
        prog = '{16'hF200, 16'h0005, 16'h0240, 16'hC000};
        load_prog(4, 0, -1);
        cycle();

        // Fetch latency
        access(0, 0, 0, 1'b0, 1'b0);
        access(1, 0, 0, 1'b0, 1'b0);
        cycle();

        // Store then load, then same-cycle write+read (read-first)
        access(0, 16'h0010, 16'hBEEF, 1'b1, 1'b0);
        access(0, 16'h0010, 0, 1'b0, 1'b1);
        access(16'h0010, 16'h0010, 16'h1234, 1'b1, 1'b1);
        access(0, 16'h0010, 0, 1'b0, 1'b1);
        cycle();

        // Oversize length clamps to the full RAM depth
        prog.delete();
        load_prog(300, 1, -1);
        cycle();

        // Out-of-range write and read
        access(0, 16'h0100, 16'hAAAA, 1'b1, 1'b0);
        access(0, 16'h0100, 0, 1'b0, 1'b1);
        access(0, 16'h0000, 0, 1'b0, 1'b1);

        // Random processor traffic
        repeat (300) begin
            access(rand_addr(), rand_addr(), int'($urandom_range(0, 65535)),
                   1'($urandom), 1'($urandom));
        end

        // Zero-length load from RUN, RAM unchanged
        load_prog(0, 0, -1);
        for (int a = 0; a < 4; a++) access(a, 0, 0, 1'b0, 1'b0);

        // Restart while loading
        prog = '{16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0};
        load_prog(4, 1, 2);
        load_prog(2, 0, -1);
        for (int a = 0; a < 4; a++) access(a, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a load keeps already-written words
        prog = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        load_prog(4, 1, 2);
        do_reset();
        repeat (2) cycle();
        load_prog(0, 0, -1);
        for (int a = 0; a < 4; a++) access(a, 0, 0, 1'b0, 1'b0);
        cycle();

        // Everything queued must have been checked
        @(negedge Clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
